// File: rtl/reg_writeback.sv
// Writeback stage: 2-entry in-order queue of {one-hot target, data} retiring into DR0-DR3.
// Latency: accept at edge N, register written at edge N+1 at the earliest; backpressure via wr_ready (state only).
module reg_writeback #(
    parameter int         DEPTH   = 2,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [3:0] wr_tgt,
    input  logic [7:0] wr_data,
    input  logic       wb_hold,
    output logic [7:0] DR0,
    output logic [7:0] DR1,
    output logic [7:0] DR2,
    output logic [7:0] DR3,
    output logic [3:0] pending,
    output logic       tgt_err
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0] state;
    logic [3:0] q_tgt [DEPTH];
    logic [7:0] q_dat [DEPTH];
    logic       accept;
    logic       retire;
    logic [3:0] in_tgt;

    // Lowest set bit wins; a zero target stays zero and writes nothing at retire.
    function automatic logic [3:0] decode(input logic [3:0] t);
        logic [3:0] d;
        d = 4'b0000;
        if (t[0])      d = 4'b0001;
        else if (t[1]) d = 4'b0010;
        else if (t[2]) d = 4'b0100;
        else if (t[3]) d = 4'b1000;
        return d;
    endfunction

    assign in_tgt   = decode(wr_tgt);
    assign wr_ready = (state != FULL);
    assign accept   = wr_valid && wr_ready;
    assign retire   = (state != EMPTY) && !wb_hold;

    // Slot 0 is always the head; a retire from FULL shifts slot 1 down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            for (int i = 0; i < DEPTH; i++) begin
                q_tgt[i] <= 4'b0000;
                q_dat[i] <= 8'h00;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        q_tgt[0] <= in_tgt;
                        q_dat[0] <= wr_data;
                        state    <= ONE;
                    end
                end
                ONE: begin
                    if (accept && retire) begin
                        q_tgt[0] <= in_tgt;
                        q_dat[0] <= wr_data;
                    end else if (accept) begin
                        q_tgt[1] <= in_tgt;
                        q_dat[1] <= wr_data;
                        state    <= FULL;
                    end else if (retire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (retire) begin
                        q_tgt[0] <= q_tgt[1];
                        q_dat[0] <= q_dat[1];
                        state    <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DR0     <= RST_VAL;
            DR1     <= RST_VAL;
            DR2     <= RST_VAL;
            DR3     <= RST_VAL;
            tgt_err <= 1'b0;
        end else begin
            tgt_err <= accept && (wr_tgt == 4'b0000);
            if (retire) begin
                if (q_tgt[0][0]) DR0 <= q_dat[0];
                if (q_tgt[0][1]) DR1 <= q_dat[0];
                if (q_tgt[0][2]) DR2 <= q_dat[0];
                if (q_tgt[0][3]) DR3 <= q_dat[0];
            end
        end
    end

    assign pending = ((state != EMPTY) ? q_tgt[0] : 4'b0000)
                   | ((state == FULL)  ? q_tgt[1] : 4'b0000);

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed steps then random traffic, checked against a queue-based model.
module tb_reg_writeback;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_tgt;
    logic [7:0] wr_data;
    logic       wb_hold;
    logic [7:0] DR0, DR1, DR2, DR3;
    logic [3:0] pending;
    logic       tgt_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a queue of {register index or -1, data}, capacity 2.
    int         m_idx [$];
    logic [7:0] m_dat [$];
    logic [7:0] m_reg [4];
    logic       m_err;

    reg_writeback #(.DEPTH(2), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_tgt(wr_tgt), .wr_data(wr_data), .wb_hold(wb_hold),
        .DR0(DR0), .DR1(DR1), .DR2(DR2), .DR3(DR3),
        .pending(pending), .tgt_err(tgt_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int low_bit(input logic [3:0] t);
        for (int i = 0; i < 4; i++) if (t[i]) return i;
        return -1;
    endfunction

    function automatic logic [3:0] m_pending();
        logic [3:0] p = 4'b0000;
        foreach (m_idx[i]) if (m_idx[i] >= 0) p[m_idx[i]] = 1'b1;
        return p;
    endfunction

    task automatic m_reset();
        m_idx.delete();
        m_dat.delete();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_err = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".DR0"},   DR0, m_reg[0]);
        chk({tag, ".DR1"},   DR1, m_reg[1]);
        chk({tag, ".DR2"},   DR2, m_reg[2]);
        chk({tag, ".DR3"},   DR3, m_reg[3]);
        chk({tag, ".pend"},  {4'b0, pending}, {4'b0, m_pending()});
        chk({tag, ".ready"}, {7'b0, wr_ready}, {7'b0, (m_idx.size() < 2)});
        chk({tag, ".err"},   {7'b0, tgt_err}, {7'b0, m_err});
    endtask

    // One clock edge: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic cyc(input string tag, input logic v, input logic [3:0] t,
                       input logic [7:0] d, input logic h);
        logic acc;
        logic ret;
        wr_valid = v;
        wr_tgt   = t;
        wr_data  = d;
        wb_hold  = h;
        acc = v && (m_idx.size() < 2);
        ret = (m_idx.size() > 0) && !h;
        @(posedge clk);
        if (ret) begin
            if (m_idx[0] >= 0) m_reg[m_idx[0]] = m_dat[0];
            void'(m_idx.pop_front());
            void'(m_dat.pop_front());
        end
        if (acc) begin
            m_idx.push_back(low_bit(t));
            m_dat.push_back(d);
        end
        m_err = acc && (t == 4'b0000);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_tgt = 4'b0; wr_data = 8'h00; wb_hold = 1'b0;
        m_reset();
        #2;
        check_all("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single write to DR2
        cyc("single_acc", 1'b1, 4'b0100, 8'h5A, 1'b0);
        chk("single_pend", {4'b0, pending}, 8'h04);
        cyc("single_ret", 1'b0, 4'b0000, 8'h00, 1'b0);
        chk("single_dr2", DR2, 8'h5A);
        cyc("single_idle", 1'b0, 4'b0000, 8'h00, 1'b0);

        // Fill under hold; third request refused
        cyc("fill1", 1'b1, 4'b0001, 8'h11, 1'b1);
        cyc("fill2", 1'b1, 4'b1000, 8'h22, 1'b1);
        chk("fill_ready", {7'b0, wr_ready}, 8'h00);
        chk("fill_pend", {4'b0, pending}, 8'h09);
        cyc("fill3", 1'b1, 4'b0100, 8'h33, 1'b1);
        cyc("drain1", 1'b1, 4'b0100, 8'h33, 1'b0);
        chk("drain1_dr0", DR0, 8'h11);
        cyc("drain2", 1'b0, 4'b0000, 8'h00, 1'b0);
        chk("drain2_dr3", DR3, 8'h22);
        cyc("drain3", 1'b0, 4'b0000, 8'h00, 1'b0);
        cyc("drain4", 1'b0, 4'b0000, 8'h00, 1'b0);

        // Same register, two queued writes: later one wins
        cyc("same1", 1'b1, 4'b0010, 8'hAA, 1'b1);
        cyc("same2", 1'b1, 4'b0010, 8'hBB, 1'b1);
        cyc("same3", 1'b0, 4'b0000, 8'h00, 1'b0);
        chk("same_dr1_a", DR1, 8'hAA);
        cyc("same4", 1'b0, 4'b0000, 8'h00, 1'b0);
        chk("same_dr1_b", DR1, 8'hBB);

        // Priority decode and zero target
        cyc("prio", 1'b1, 4'b1110, 8'hC3, 1'b0);
        cyc("zero", 1'b1, 4'b0000, 8'hFF, 1'b0);
        chk("prio_dr1", DR1, 8'hC3);
        chk("zero_err", {7'b0, tgt_err}, 8'h01);
        cyc("zero_ret", 1'b0, 4'b0000, 8'h00, 1'b0);
        chk("zero_err_end", {7'b0, tgt_err}, 8'h00);

        // Streaming with hold low
        for (int i = 0; i < 8; i++) begin
            cyc("stream", 1'b1, 4'b0001 << (i % 4), 8'h40 + 8'(i), 1'b0);
            chk("stream_ready", {7'b0, wr_ready}, 8'h01);
        end
        cyc("stream_end", 1'b0, 4'b0000, 8'h00, 1'b0);

        // Asynchronous reset with two entries queued
        cyc("pre_rst1", 1'b1, 4'b0001, 8'h77, 1'b1);
        cyc("pre_rst2", 1'b1, 4'b0010, 8'h88, 1'b1);
        wr_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        m_reset();
        #1;
        check_all("async_rst");
        #1;
        rst_n = 1'b1;
        cyc("post_rst", 1'b0, 4'b0000, 8'h00, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] t;
            t = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
            cyc("rand", ($urandom_range(0, 3) != 0), t, 8'($urandom),
                ($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
